// File: rtl/operand_collector_pkg.sv
// Shared encodings for the operand collector: FSM states and opcode values.
// The testbench and neighbouring blocks import this package, so they all use the same numbers.
package operand_collector_pkg;

  typedef enum logic [2:0] {
    COLLECT_OP,
    COLLECT_A,
    COLLECT_B,
    EXEC,
    HOLD
  } state_t;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_ADD  = 3'd0;
  localparam opcode_t OP_SUB  = 3'd1;
  localparam opcode_t OP_AND  = 3'd2;
  localparam opcode_t OP_OR   = 3'd3;
  localparam opcode_t OP_XOR  = 3'd4;
  localparam opcode_t OP_SHL  = 3'd5;
  localparam opcode_t OP_SHR  = 3'd6;
  localparam opcode_t OP_PASS = 3'd7;

endpackage

// File: rtl/operand_collector_alu.sv
// Combinational datapath for the operand collector.
// Carry is the (WIDTH+1)-th bit of the add/sub; it is 0 for every other op.
module collector_alu
  import operand_collector_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  opcode_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  // Shift distance uses only the low log2(WIDTH) bits of B.
  assign shamt = b[SHW-1:0];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (op)
      OP_ADD:  {carry, res} = sum;
      OP_SUB:  {carry, res} = diff;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SHL:  res = a << shamt;
      OP_SHR:  res = a >> shamt;
      OP_PASS: res = a;
    endcase
  end

endmodule

// File: rtl/operand_collector.sv
// Collects opcode, A and B words from the upstream deserializer, executes once,
// and holds the registered result until the consumer acknowledges it.
module operand_collector
  import operand_collector_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             busy,
  output logic             overrun
);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("operand_collector: WIDTH must be a power of two and at least 4");
  end

  state_t           state;
  state_t           state_next;
  opcode_t          op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  collector_alu #(.WIDTH(WIDTH)) u_alu (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .res   (alu_res),
    .carry (alu_carry)
  );

  always_comb begin
    state_next = state;
    case (state)
      COLLECT_OP: if (word_valid) state_next = COLLECT_A;
      COLLECT_A:  if (word_valid) state_next = COLLECT_B;
      COLLECT_B:  if (word_valid) state_next = EXEC;
      EXEC:       state_next = HOLD;
      HOLD:       if (result_ack) state_next = COLLECT_OP;
      default:    state_next = COLLECT_OP;
    endcase
  end

  assign busy = (state != COLLECT_OP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= COLLECT_OP;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result       <= '0;
      carry        <= 1'b0;
      zero         <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state <= state_next;

      if (word_valid) begin
        case (state)
          COLLECT_OP: op_q    <= word_in[2:0];
          COLLECT_A:  a_q     <= word_in;
          COLLECT_B:  b_q     <= word_in;
          default:    overrun <= 1'b1;  // EXEC/HOLD: word is dropped
        endcase
      end

      // Result registers change only in EXEC; after the ack they keep their values.
      if (state == EXEC) begin
        result       <= alu_res;
        carry        <= alu_carry;
        zero         <= (alu_res == '0);
        result_valid <= 1'b1;
      end else if (state == HOLD && result_ack) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector: a table of full operations plus
// hand-written sequences for hold/overrun, ack-outside-hold and mid-operation reset.
module tb_operand_collector;
  import operand_collector_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             result_valid;
  logic             result_ack;
  logic             busy;
  logic             overrun;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] op_w;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  operand_collector #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .result       (result),
    .carry        (carry),
    .zero         (zero),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // One-cycle word_valid pulse, driven at the falling edge and sampled on the next rising edge.
  task automatic send_word(input logic [7:0] w);
    @(negedge clk);
    word_in    = w;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    word_in    = '0;
  endtask

  task automatic ack();
    @(negedge clk);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
  endtask

  // Sends op/A/B and checks latency and outputs; leaves the DUT in HOLD.
  task automatic run_op(input string name, input logic [7:0] op_w, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_res,
                        input logic exp_c, input logic exp_z);
    send_word(op_w);
    send_word(a);
    send_word(b);
    check({name, "_rv_early"}, 32'(result_valid), 32'd0);
    @(negedge clk);
    check({name, "_rv"},    32'(result_valid), 32'd1);
    check({name, "_res"},   32'(result),       32'(exp_res));
    check({name, "_carry"}, 32'(carry),        32'(exp_c));
    check({name, "_zero"},  32'(zero),         32'(exp_z));
    check({name, "_busy"},  32'(busy),         32'd1);
  endtask

  initial begin
    vecs[0]  = '{8'h00, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};  // ADD with carry
    vecs[1]  = '{8'h01, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1};  // SUB to zero
    vecs[2]  = '{8'h01, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};  // SUB with borrow
    vecs[3]  = '{8'h05, 8'h81, 8'h09, 8'h02, 1'b0, 1'b0};  // SHL, B masked to 1
    vecs[4]  = '{8'hFD, 8'h81, 8'h09, 8'h02, 1'b0, 1'b0};  // opcode upper bits ignored
    vecs[5]  = '{8'h02, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0};  // AND
    vecs[6]  = '{8'h03, 8'hCC, 8'h0A, 8'hCE, 1'b0, 1'b0};  // OR
    vecs[7]  = '{8'h04, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1};  // XOR to zero
    vecs[8]  = '{8'h06, 8'h80, 8'h0F, 8'h01, 1'b0, 1'b0};  // SHR by 7
    vecs[9]  = '{8'h07, 8'h3C, 8'hFF, 8'h3C, 1'b0, 1'b0};  // PASS
    vecs[10] = '{8'h00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};  // ADD wraps to zero
    vecs[11] = '{8'h01, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};  // SUB no borrow

    rst        = 1'b0;
    word_in    = '0;
    word_valid = 1'b0;
    result_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_result", 32'(result),       32'd0);
    check("reset_carry",  32'(carry),        32'd0);
    check("reset_zero",   32'(zero),         32'd0);
    check("reset_rv",     32'(result_valid), 32'd0);
    check("reset_ovr",    32'(overrun),      32'd0);
    check("reset_busy",   32'(busy),         32'd0);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op_w, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].c, vecs[i].z);
      // Results must stay put for a few cycles while unacknowledged.
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_hold_rv", i),  32'(result_valid), 32'd1);
      check($sformatf("vec%0d_hold_res", i), 32'(result),       32'(vecs[i].res));
      ack();
      check($sformatf("vec%0d_ack_rv", i),   32'(result_valid), 32'd0);
      check($sformatf("vec%0d_ack_busy", i), 32'(busy),         32'd0);
      check($sformatf("vec%0d_ack_res", i),  32'(result),       32'(vecs[i].res));
      check($sformatf("vec%0d_ack_c", i),    32'(carry),        32'(vecs[i].c));
    end
    check("no_overrun_yet", 32'(overrun), 32'd0);

    // result_ack while collecting has no effect.
    send_word(8'h00);
    @(negedge clk);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    check("ign_ack_busy", 32'(busy), 32'd1);
    send_word(8'h01);
    send_word(8'h02);
    @(negedge clk);
    check("ign_ack_rv",  32'(result_valid), 32'd1);
    check("ign_ack_res", 32'(result),       32'h03);
    ack();

    // Word during HOLD is dropped and sets overrun; then ack coinciding with a word.
    run_op("ovr_add", 8'h00, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);
    @(negedge clk);
    word_in    = 8'h33;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    check("ovr_flag",    32'(overrun),      32'd1);
    check("ovr_rv",      32'(result_valid), 32'd1);
    check("ovr_res",     32'(result),       32'h30);
    word_in    = 8'h33;
    word_valid = 1'b1;
    result_ack = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    result_ack = 1'b0;
    check("ovr_ack_rv",   32'(result_valid), 32'd0);
    check("ovr_ack_busy", 32'(busy),         32'd0);
    check("ovr_ack_res",  32'(result),       32'h30);
    run_op("after_ovr", 8'h00, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
    check("ovr_sticky", 32'(overrun), 32'd1);
    ack();

    // Reset in the middle of collection abandons the partial operation.
    send_word(8'h00);
    send_word(8'h11);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_result", 32'(result),       32'd0);
    check("mid_rst_carry",  32'(carry),        32'd0);
    check("mid_rst_zero",   32'(zero),         32'd0);
    check("mid_rst_rv",     32'(result_valid), 32'd0);
    check("mid_rst_ovr",    32'(overrun),      32'd0);
    check("mid_rst_busy",   32'(busy),         32'd0);
    run_op("post_rst", 8'h07, 8'h3C, 8'h00, 8'h3C, 1'b0, 1'b0);
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_collector.md
OPERAND_COLLECTOR -- requirements
Module: operand_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the word width; it SHALL be at least 4 and a power of two.
REQ-002 SHALL have clk  input  1  clock; all logic on the rising edge.
REQ-003 SHALL have rst  input  1  reset; synchronous, active-low.
REQ-004 SHALL have word_in  input  WIDTH  deserialized word from the upstream bit-serial input buffer.
REQ-005 SHALL have word_valid  input  1  single-cycle pulse qualifying word_in.
REQ-006 SHALL have result  output  WIDTH  registered operation result.
REQ-007 SHALL have carry  output  1  carry-out for ADD, borrow for SUB, 0 for every other op.
REQ-008 SHALL have zero  output  1  high when result equals 0.
REQ-009 SHALL have result_valid  output  1  result/carry/zero are valid; held until acknowledged.
REQ-010 SHALL have result_ack  input  1  consumer acknowledge.
REQ-011 SHALL have busy  output  1  high in every state except COLLECT_OP.
REQ-012 SHALL have overrun  output  1  sticky flag; a word was dropped.

Function
REQ-013 SHALL implement the FSM states COLLECT_OP, COLLECT_A, COLLECT_B, EXEC and HOLD.
REQ-014 COLLECT_OP SHALL latch word_in[2:0] as the opcode on word_valid and go to COLLECT_A; bits above [2] are ignored.
REQ-015 COLLECT_A SHALL latch operand A on word_valid and go to COLLECT_B.
REQ-016 COLLECT_B SHALL latch operand B on word_valid and go to EXEC.
REQ-017 Without word_valid, each collect state SHALL hold; there is no timeout.
REQ-018 EXEC SHALL last exactly one cycle, register result/carry/zero, set result_valid, and go to HOLD.
REQ-019 Latency SHALL be: word_valid for B in cycle n gives result_valid high in cycle n+2.
REQ-020 Opcodes SHALL be:
- 0 ADD A+B
- 1 SUB A-B
- 2 AND
- 3 OR
- 4 XOR
- 5 SHL A by B[log2(WIDTH)-1:0]
- 6 SHR (logical) A by B[log2(WIDTH)-1:0]
- 7 PASS A
REQ-021 Arithmetic SHALL be unsigned modulo 2^WIDTH; carry is bit WIDTH of the (WIDTH+1)-bit sum or difference.
REQ-022 HOLD SHALL keep result_valid and all result outputs stable until result_ack is sampled high; the next cycle then has result_valid=0 and state COLLECT_OP.
REQ-023 result_ack outside HOLD SHALL be ignored.
REQ-024 word_valid in EXEC or HOLD SHALL drop the word and set overrun, including when it coincides with result_ack.
REQ-025 overrun SHALL clear only on reset.
REQ-026 result, carry and zero SHALL keep their last values after the acknowledge until the next EXEC.

Reset
REQ-027 When rst=0 at a clock edge, the block SHALL go to state COLLECT_OP with result=0, carry=0, zero=0, result_valid=0 and overrun=0; opcode, A and B are cleared.
REQ-028 Reset mid-collection or in HOLD SHALL abandon any partial operation; the first word_valid after reset is treated as an opcode.
REQ-029 busy SHALL be 0 in the cycle following reset.

Structure
REQ-030 A shared package SHALL hold the state enumeration and the opcode constants (OP_ADD..OP_PASS), so the testbench and neighbouring blocks use the same encodings.
REQ-031 The datapath SHALL be a combinational sub-module collector_alu (inputs op, a, b; outputs res, carry) instantiated once; the FSM and all registers stay in operand_collector.

Verification
REQ-032 ADD with carry: words 0x00, 0xF0, 0x20 -> result 0x10, carry 1, zero 0, result_valid exactly 2 cycles after the third pulse.
REQ-033 SUB borrow and zero: words 0x01, 0x05, 0x05 -> result 0x00, zero 1, carry 0; then words 0x01, 0x03, 0x05 -> result 0xFE, carry 1.
REQ-034 Shift masking: words 0x05, 0x81, 0x09 -> SHL by 1 -> result 0x02, carry 0; opcode word 0xFD decodes as op 5.
REQ-035 Overrun and hold: in HOLD, pulse word_valid 0x33 with ack held low -> overrun 1, result unchanged; then assert ack together with word_valid -> word dropped, result_valid 0 next cycle, state COLLECT_OP.
REQ-036 Reset mid-operation: send 0x00, 0x11, then rst low for one cycle -> all outputs 0, busy 0; then 0x07, 0x3C, 0x00 -> result 0x3C.
